// File: rtl/retire_monitor.sv
// retire_monitor
//
// Watches the pc/result pair coming out of the cpu every clock and infers
// instruction retirement from pc changes. Each retirement bumps a saturating
// counter and folds the retired result into a rotate-xor signature. A pc that
// stays put for HALT_COUNT consecutive samples is the self-loop halt idiom
// (jal x0, 0), after which everything freezes until reset.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset, clears all state immediately
//   pcw        current pc from the cpu
//   result     current result from the cpu
//   retired    number of retirement events seen (saturates at all-ones)
//   signature  rotate-left-by-one xor accumulation of retired results
//   last_pc    pc value captured at the most recent prime/retire edge
//   halted     sticky halt flag
module retire_monitor #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 32,
  parameter int HALT_COUNT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pcw,
  input  logic [DATA_WIDTH-1:0]    result,
  output logic [CNT_WIDTH-1:0]     retired,
  output logic [DATA_WIDTH-1:0]    signature,
  output logic [ADDRESS_WIDTH-1:0] last_pc,
  output logic                     halted
);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  // HALT_COUNT is at most 255, so the stall counter never needs more than
  // 8 bits: it only ever holds values below HALT_COUNT before halting.
  localparam logic [7:0] HALT_TARGET = 8'(HALT_COUNT);

  state_t     state;
  logic [7:0] same_cnt;
  logic [7:0] same_next;
  logic [DATA_WIDTH-1:0] sig_next;

  // Next-value helpers kept combinational so the sequential block reads as
  // a plain list of per-state actions.
  always_comb begin
    same_next = same_cnt + 8'd1;
    sig_next  = {signature[DATA_WIDTH-2:0], signature[DATA_WIDTH-1]} ^ result;
  end

  // The whole monitor is one registered state machine. PRIME only captures
  // the pc so the first post-reset edge can never look like a retirement.
  // In RUN every edge is either a retirement (pc moved) or a stall count
  // (pc held); a pc move always wins over completing the halt count.
  // HALT does nothing at all, which freezes every output until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PRIME;
      retired   <= '0;
      signature <= '0;
      last_pc   <= '0;
      halted    <= 1'b0;
      same_cnt  <= 8'd0;
    end else begin
      case (state)
        PRIME: begin
          last_pc  <= pcw;
          same_cnt <= 8'd0;
          state    <= RUN;
        end
        RUN: begin
          if (pcw != last_pc) begin
            if (retired != {CNT_WIDTH{1'b1}}) begin
              retired <= retired + CNT_WIDTH'(1);
            end
            signature <= sig_next;
            last_pc   <= pcw;
            same_cnt  <= 8'd0;
          end else begin
            same_cnt <= same_next;
            if (same_next == HALT_TARGET) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor
//
// Directed bench for retire_monitor. Two instances share the same inputs:
// dut uses the default 32-bit counter, dut_sat uses a 3-bit counter so
// saturation can be reached in a handful of retirements.
module tb_retire_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] pcw;
  logic [31:0] result;

  logic [31:0] retired;
  logic [31:0] signature;
  logic [31:0] last_pc;
  logic        halted;

  logic [2:0]  sat_retired;
  logic [31:0] sat_signature;
  logic [31:0] sat_last_pc;
  logic        sat_halted;

  int tests;
  int failures;

  retire_monitor #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32), .HALT_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .pcw(pcw), .result(result),
    .retired(retired), .signature(signature), .last_pc(last_pc), .halted(halted)
  );

  retire_monitor #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(3), .HALT_COUNT(4)
  ) dut_sat (
    .clk(clk), .rst(rst), .pcw(pcw), .result(result),
    .retired(sat_retired), .signature(sat_signature),
    .last_pc(sat_last_pc), .halted(sat_halted)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, outputs are sampled 1 ns after the
  // rising edge that consumed them.
  task automatic step(input logic [31:0] pc, input logic [31:0] res);
    @(negedge clk);
    pcw    = pc;
    result = res;
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges with the given pc, releases it on a falling
  // edge, then lets the prime edge happen.
  task automatic reset_and_prime(input logic [31:0] pc);
    @(negedge clk);
    rst    = 1'b1;
    pcw    = pc;
    result = 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [31:0] exp_ret,
                           input logic [31:0] exp_sig, input logic [31:0] exp_pc,
                           input logic exp_halt);
    tests++;
    if (retired !== exp_ret) begin
      failures++;
      $display("[TB] FAIL %s retired: got %h expected %h", name, retired, exp_ret);
    end
    tests++;
    if (signature !== exp_sig) begin
      failures++;
      $display("[TB] FAIL %s signature: got %h expected %h", name, signature, exp_sig);
    end
    tests++;
    if (last_pc !== exp_pc) begin
      failures++;
      $display("[TB] FAIL %s last_pc: got %h expected %h", name, last_pc, exp_pc);
    end
    tests++;
    if (halted !== exp_halt) begin
      failures++;
      $display("[TB] FAIL %s halted: got %b expected %b", name, halted, exp_halt);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst    = 1'b1;
    pcw    = 32'h40;
    result = 32'h0;
    @(posedge clk);
    #1;
    check_all("reset_held", 32'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("prime", 32'd0, 32'h0, 32'h40, 1'b0);
  endtask

  task automatic test_retire;
    reset_and_prime(32'h0);
    step(32'h4, 32'h5);
    check_all("retire1", 32'd1, 32'h5, 32'h4, 1'b0);
    step(32'h8, 32'h3);
    check_all("retire2", 32'd2, 32'h9, 32'h8, 1'b0);
    step(32'hC, 32'h8000_0000);
    check_all("retire3", 32'd3, 32'h8000_0012, 32'hC, 1'b0);
  endtask

  // Continues from test_retire: edge K moves pc to 0x10, then pc holds.
  task automatic test_halt;
    step(32'h10, 32'h1);
    check_all("halt_k", 32'd4, 32'h24, 32'h10, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(32'h10, 32'hDEAD);
      check_all($sformatf("halt_k+%0d", i), 32'd4, 32'h24, 32'h10, 1'b0);
    end
    step(32'h10, 32'hDEAD);
    check_all("halt_k+4", 32'd4, 32'h24, 32'h10, 1'b1);
    step(32'h14, 32'hFF);
    check_all("halt_frozen", 32'd4, 32'h24, 32'h10, 1'b1);
    step(32'h18, 32'h77);
    check_all("halt_frozen2", 32'd4, 32'h24, 32'h10, 1'b1);
  endtask

  task automatic test_near_halt;
    reset_and_prime(32'h100);
    for (int i = 1; i <= 3; i++) begin
      step(32'h100, 32'hAA);
      check_all($sformatf("near_hold%0d", i), 32'd0, 32'h0, 32'h100, 1'b0);
    end
    // The pc moves on the edge that would have completed the count.
    step(32'h104, 32'h7);
    check_all("near_change", 32'd1, 32'h7, 32'h104, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(32'h104, 32'hBB);
      check_all($sformatf("near_rehold%0d", i), 32'd1, 32'h7, 32'h104, 1'b0);
    end
    step(32'h104, 32'hBB);
    check_all("near_rehold4", 32'd1, 32'h7, 32'h104, 1'b1);
  endtask

  task automatic test_async_reset;
    reset_and_prime(32'h0);
    // results 1..5 give signature 1, 0, 3, 2, 1
    for (int i = 1; i <= 5; i++) begin
      step(32'(i * 4), 32'(i));
    end
    check_all("pre_pulse", 32'd5, 32'h1, 32'h14, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    pcw = 32'h200;
    #1;
    check_all("during_pulse", 32'd0, 32'h0, 32'h0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_pulse_prime", 32'd0, 32'h0, 32'h200, 1'b0);
    step(32'h204, 32'h9);
    check_all("post_pulse_retire", 32'd1, 32'h9, 32'h204, 1'b0);
  endtask

  task automatic test_saturation;
    logic [31:0] exp_sig;
    logic [2:0]  exp_sat;
    exp_sig = 32'h0;
    reset_and_prime(32'h0);
    for (int i = 1; i <= 9; i++) begin
      step(32'(i * 4), 32'(i * 32'h0101_0101));
      exp_sig = {exp_sig[30:0], exp_sig[31]} ^ 32'(i * 32'h0101_0101);
      exp_sat = (i >= 7) ? 3'd7 : 3'(i);
      tests++;
      if (sat_retired !== exp_sat) begin
        failures++;
        $display("[TB] FAIL sat_retired%0d: got %0d expected %0d", i, sat_retired, exp_sat);
      end
      tests++;
      if (sat_signature !== exp_sig) begin
        failures++;
        $display("[TB] FAIL sat_signature%0d: got %h expected %h", i, sat_signature, exp_sig);
      end
      tests++;
      if (retired !== 32'(i)) begin
        failures++;
        $display("[TB] FAIL wide_retired%0d: got %0d expected %0d", i, retired, i);
      end
    end
  endtask

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    pcw      = 32'h0;
    result   = 32'h0;
    test_reset();
    test_retire();
    test_halt();
    test_near_halt();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/retire_monitor.md
# retire_monitor

Retirement monitor that sits directly downstream of `cpu` and consumes its `pcw` and `result` outputs every clock. It infers instruction retirement from PC changes and counts retired instructions. It folds each retired `result` into a rotate-XOR signature and detects the self-loop halt idiom (`jal x0, 0`). Benches and FPGA top levels use it to end simulation and compare a single signature word against a golden value.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, width of `pcw` and `last_pc`.
- `DATA_WIDTH`, 32, width of `result` and `signature`.
- `CNT_WIDTH`, 32, width of the retired-instruction counter.
- `HALT_COUNT`, 4, consecutive unchanged-PC samples that declare halt. Legal range is 2..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `pcw`  in  ADDRESS_WIDTH  current PC from `cpu`.
- `result`  in  DATA_WIDTH  current result from `cpu`.
- `retired`  out  CNT_WIDTH  count of retirement events.
- `signature`  out  DATA_WIDTH  rotate-XOR accumulation of retired results.
- `last_pc`  out  ADDRESS_WIDTH  PC value sampled at the most recent edge.
- `halted`  out  1  high once the halt condition is met; sticky until `rst`.

## Operation
- State machine: PRIME, RUN, HALT. Reset state is PRIME.
- PRIME, on the first rising edge after `rst` deasserts:
  - `last_pc` <= `pcw`.
  - No retirement, no signature update.
  - Next state is RUN.
- RUN, `pcw != last_pc` (retirement event):
  - `retired` <= `retired + 1`, saturating at all-ones.
  - `signature` <= rotl1(`signature`) ^ `result`. rotl1 rotates left by one over DATA_WIDTH bits, MSB wraps to bit 0.
  - `last_pc` <= `pcw`.
  - `same_cnt` <= 0.
- RUN, `pcw == last_pc`:
  - `same_cnt` <= `same_cnt + 1`.
  - If the incremented value equals `HALT_COUNT`: next state is HALT and `halted` <= 1.
  - `retired`, `signature` and `last_pc` are unchanged.
- HALT:
  - All outputs frozen regardless of `pcw`/`result`.
  - Only `rst` exits HALT.
- `same_cnt` is internal, at least 8 bits, reset to 0.
- Reset values: `retired` = 0, `signature` = 0, `last_pc` = 0, `halted` = 0, state PRIME.
- Width rules:
  - Counter saturation: `retired` stays at 2^CNT_WIDTH-1. It never wraps.
  - Signature arithmetic is modulo 2^DATA_WIDTH; there is no carry.

## Timing
- All outputs are registered.
- An event sampled at edge N is visible on the outputs after edge N. Latency is one cycle from `pcw`/`result` to the outputs.
- Inputs are sampled only at rising edges; glitches between edges are ignored.
- Halt timing: if `pcw` last changed at edge K, `halted` rises after edge K+HALT_COUNT.
- A PC change at the same edge that would have completed the count is a retirement. `same_cnt` clears and no halt occurs.
- Reset mid-operation:
  - Asserting `rst` at any time, including mid-cycle, clears all outputs without waiting for `clk`.
  - After release, the block re-enters PRIME. The first post-reset edge never counts a retirement.
- Each edge is exactly one of: prime, retire, stall-count, or frozen. There are no multi-event edges.

## Test plan
- Reset/prime: hold `rst` high and drive `pcw`=0x40. Then release; after the first edge, require `last_pc`=0x40, `retired`=0, `signature`=0, `halted`=0.
- Retire/signature:
  - Stimulus: after prime at `pcw`=0, drive (`pcw`,`result`) = (4,0x5), (8,0x3), (0xC,0x80000000).
  - Required: `retired`=1/2/3 and `signature`=0x5, 0x9, 0x80000012 after each successive edge.
- Halt with HALT_COUNT=4:
  - Stimulus: `pcw` changes to 0x10 at edge K, then holds at 0x10.
  - Required: `halted`=0 through edge K+3 and =1 after K+4.
  - After halt, changing `pcw` to 0x14 with `result`=0xFF leaves `retired`, `signature` and `last_pc` unchanged.
- Near-halt recovery: hold `pcw` for 3 edges (HALT_COUNT=4), then change it. Require `halted`=0, `retired` incremented, and a subsequent fresh 4-edge hold needed to halt.
- Async reset mid-run:
  - Stimulus: with `retired`=5 and a nonzero signature, pulse `rst` for 2 ns between clock edges.
  - Required: all outputs 0 during the pulse, before any `clk` edge. The next edge primes without counting.
- Saturation: with CNT_WIDTH=3, drive 9 distinct PCs after prime. Require `retired` to hold at 7 after the 7th retirement while `signature` keeps updating.
